cdce_spi_arbiter: RTL and testbench

//   Shares the single CDCE serial-out engine between two command requesters:
//   req0 = boot configuration controller, req1 = runtime register-write path.

---
 rtl/cdce_spi_arbiter.sv | 88 ++++++++
 tb/tb_cdce_spi_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/cdce_spi_arbiter.sv
// cdce_spi_arbiter: round-robin sharing of the CDCE serial-out engine between two command requesters
module cdce_spi_arbiter #(
  parameter int CMD_WIDTH      = 20,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic                 req0_valid_i,
  input  logic [CMD_WIDTH-1:0] req0_cmd_i,
  output logic                 req0_ack_o,
  input  logic                 req1_valid_i,
  input  logic [CMD_WIDTH-1:0] req1_cmd_i,
  output logic                 req1_ack_o,
  input  logic                 serial_ready_i,
  output logic                 start_transaction_o,
  output logic [CMD_WIDTH-1:0] command_out_o,
  output logic                 busy_o,
  output logic                 timeout_err_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_e;
  state_e               state_q;
  logic [1:0]           rst_sync_q;
  logic                 rst_n;
  logic                 last_q, owner_q, ack0_q, ack1_q, start_q, busy_q, err_q;
  logic [CMD_WIDTH-1:0] cmd_q;
  logic [CW-1:0]        cnt_q;
  logic                 grant, pick1, tmo, advance, done, abort;
  // reset asserts immediately and releases two clocks after rst_ni rises
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) rst_sync_q <= '0;
    else rst_sync_q <= {rst_sync_q[0], 1'b1};
  assign rst_n = rst_sync_q[1];
  // winner selection, no grant in the ack cycle, and wait-state exits
  always_comb begin
    pick1   = req1_valid_i & (~req0_valid_i | ~last_q);
    grant   = enable_i & serial_ready_i & (req0_valid_i | req1_valid_i) & ~ack0_q & ~ack1_q;
    tmo     = cnt_q == CW'(TIMEOUT_CYCLES);
    advance = (state_q == WAIT_BUSY) & ~serial_ready_i;
    done    = (state_q == WAIT_DONE) & serial_ready_i;
    abort   = (state_q != IDLE) & ~advance & ~done & tmo;
  end
  // transaction FSM with registered handshake outputs
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      cmd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      start_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err_q   <= 1'b0;
      if (state_q == IDLE) begin
        busy_q <= grant;
        if (grant) begin
          owner_q <= pick1;
          cmd_q   <= pick1 ? req1_cmd_i : req0_cmd_i;
          start_q <= 1'b1;
          cnt_q   <= '0;
          state_q <= WAIT_BUSY;
        end
      end else if (advance) begin
        cnt_q   <= '0;
        state_q <= WAIT_DONE;
      end else if (done | abort) begin
        ack0_q  <= ~owner_q;
        ack1_q  <= owner_q;
        err_q   <= abort;
        last_q  <= owner_q;
        state_q <= IDLE;
      end else cnt_q <= cnt_q + CW'(1);
    end
  assign req0_ack_o          = ack0_q;
  assign req1_ack_o          = ack1_q;
  assign start_transaction_o = start_q;
  assign command_out_o       = cmd_q;
  assign busy_o              = busy_q;
  assign timeout_err_o       = err_q;
endmodule

// File: tb/tb_cdce_spi_arbiter.sv
// tb_cdce_spi_arbiter: randomized transaction-level check of the CDCE serial-out arbiter
module tb_cdce_spi_arbiter;
  localparam int CW = 20;
  localparam int T  = 16;
  logic          clk = 1'b0, rst_n = 1'b0, enable = 1'b0, r0v = 1'b0, r1v = 1'b0, rdy = 1'b1;
  logic [CW-1:0] c0 = '0, c1 = '0, cmd;
  logic          a0, a1, start, busy, err;
  int            tests = 0, fails = 0, last = 1;
  always #5 clk = ~clk;
  cdce_spi_arbiter #(.CMD_WIDTH(CW), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
    .req0_valid_i(r0v), .req0_cmd_i(c0), .req0_ack_o(a0),
    .req1_valid_i(r1v), .req1_cmd_i(c1), .req1_ack_o(a1),
    .serial_ready_i(rdy), .start_transaction_o(start), .command_out_o(cmd),
    .busy_o(busy), .timeout_err_o(err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic outs_zero(input string tag);
    check({tag, "_start"}, 32'(start), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_ack0"}, 32'(a0), 0);
    check({tag, "_ack1"}, 32'(a1), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_cmd"}, 32'(cmd), 0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    rdy   = 1'b1;
    repeat (2) @(negedge clk);
    outs_zero("reset");
    rst_n = 1'b1;
    last  = 1;
    repeat (3) @(negedge clk);
  endtask
  // drop: cycles after the start cycle at which the engine lowers ready (>T: never in time)
  // hold: cycles ready stays low; the engine recovers to ready=1 after the ack
  task automatic txn(input int drop, input int hold, input int max_wait, input bit drop_v,
                     input bit drop_en, output int w);
    logic [CW-1:0] ec;
    int            a;
    bit            to;
    w  = (r0v && r1v) ? 1 - last : (r1v ? 1 : 0);
    ec = w ? c1 : c0;
    for (int n = 0; n < max_wait && !start; n++) @(negedge clk);
    check("start_seen", 32'(start), 1);
    check("cmd", 32'(cmd), 32'(ec));
    check("busy_at_start", 32'(busy), 1);
    if (drop_v) begin
      if (w == 1) r1v = 1'b0;
      else r0v = 1'b0;
    end
    if (drop_en) enable = 1'b0;
    to  = (drop > T) || (hold > T + 1);
    a   = drop > T ? T + 1 : (hold > T + 1 ? drop + T + 2 : drop + hold + 1);
    rdy = 1'b1;
    for (int k = 1; k <= a; k++) begin
      @(negedge clk);
      check("start_width", 32'(start), 0);
      check("ack0", 32'(a0), 32'(k == a && w == 0));
      check("ack1", 32'(a1), 32'(k == a && w == 1));
      check("timeout_err", 32'(err), 32'(k == a && to));
      check("busy", 32'(busy), 1);
      rdy = !(k >= drop && k < drop + hold);
    end
    rdy  = 1'b1;
    last = w;
    @(negedge clk);
    check("gap_start", 32'(start), 0);
    check("busy_after", 32'(busy), 0);
    check("ack_after", 32'(a0 | a1), 0);
    check("cmd_hold", 32'(cmd), 32'(ec));
  endtask
  initial begin
    int w, n;
    do_reset();
    enable = 1'b1;
    // round robin with both held valid from reset: 0,1,0,1
    r0v = 1'b1;
    r1v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c0 = CW'($urandom);
      c1 = CW'($urandom);
      txn($urandom_range(1, 4), $urandom_range(1, 10), 1, 1'b0, 1'b0, w);
      check("rr_order", 32'(dut.command_out_o == (i % 2 == 1 ? c1 : c0)), 1);
    end
    r0v = 1'b0;
    r1v = 1'b0;
    @(negedge clk);
    // single req0 transaction from reset
    do_reset();
    c0  = 20'hA5A5A;
    r0v = 1'b1;
    txn(1, 12, 1, 1'b0, 1'b0, w);
    r0v = 1'b0;
    @(negedge clk);
    // engine never leaves ready: timeout 17 cycles after start
    c1  = CW'($urandom);
    r1v = 1'b1;
    txn(1000, 1, 1, 1'b0, 1'b0, w);
    r1v = 1'b0;
    // enable low blocks grants
    enable = 1'b0;
    r0v    = 1'b1;
    r1v    = 1'b1;
    c0     = CW'($urandom);
    c1     = CW'($urandom);
    n      = 0;
    repeat (100) begin
      @(negedge clk);
      n += int'(start);
    end
    check("disabled_starts", 32'(n), 0);
    enable = 1'b1;
    txn(2, 5, 1, 1'b0, 1'b0, w);
    r0v = 1'b0;
    r1v = 1'b0;
    @(negedge clk);
    // requester withdraws valid right after its grant
    r1v = 1'b1;
    c1  = CW'($urandom);
    txn(1, 4, 1, 1'b1, 1'b0, w);
    // reset during WAIT_DONE, then a pending req1 is served
    r1v = 1'b1;
    c1  = CW'($urandom);
    @(negedge clk);
    check("pre_reset_start", 32'(start), 1);
    rdy = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    outs_zero("midreset");
    repeat (2) @(negedge clk);
    rdy   = 1'b1;
    rst_n = 1'b1;
    last  = 1;
    txn(1, 3, 8, 1'b0, 1'b0, w);
    r1v = 1'b0;
    @(negedge clk);
    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      int v, g;
      bit de;
      v   = $urandom_range(1, 3);
      r0v = v[0];
      r1v = v[1];
      c0  = CW'($urandom);
      c1  = CW'($urandom);
      g   = $urandom_range(0, 3);
      if (g > 0) begin
        rdy = 1'b0;
        repeat (g) begin
          @(negedge clk);
          check("no_grant_not_ready", 32'(start), 0);
        end
        rdy = 1'b1;
      end
      de = $urandom_range(0, 3) == 0;
      txn($urandom_range(1, 20), $urandom_range(1, 20), 1, $urandom_range(0, 3) == 0, de, w);
      if (de) begin
        repeat (3) begin
          @(negedge clk);
          check("no_grant_disabled", 32'(start), 0);
        end
        enable = 1'b1;
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
